// File: rtl/exe_operand_stage_pkg.sv
// Shared encodings for the EX operand stage: ALU op codes, operand
// selects and the registered ID/EX bundle with its bubble value.
package exe_operand_stage_pkg;

   localparam logic [3:0] EXE_ALU_AND = 4'h0;
   localparam logic [3:0] EXE_ALU_OR  = 4'h1;
   localparam logic [3:0] EXE_ALU_ADD = 4'h2;
   localparam logic [3:0] EXE_ALU_SUB = 4'h6;
   localparam logic [3:0] EXE_ALU_SLT = 4'h7;
   localparam logic [3:0] EXE_ALU_SLL = 4'h8;
   localparam logic [3:0] EXE_ALU_SRL = 4'h9;
   localparam logic [3:0] EXE_ALU_SRA = 4'hA;

   localparam logic [1:0] EXE_A_RS   = 2'd0;
   localparam logic [1:0] EXE_A_SA   = 2'd1;
   localparam logic [1:0] EXE_A_PC   = 2'd2;
   localparam logic [1:0] EXE_A_RSV  = 2'd3;

   localparam logic [1:0] EXE_B_RT   = 2'd0;
   localparam logic [1:0] EXE_B_IMM  = 2'd1;
   localparam logic [1:0] EXE_B_FOUR = 2'd2;
   localparam logic [1:0] EXE_B_ZERO = 2'd3;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm_ext;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [4:0]  wb_addr;
      logic        wb_en;
      logic        mem_ren;
      logic        mem_wen;
      logic [3:0]  alu_oper;
      logic [1:0]  a_sel;
      logic [1:0]  b_sel;
   } id_ex_t;

   function automatic id_ex_t bubble();
      id_ex_t b;
      b          = '0;
      b.alu_oper = EXE_ALU_ADD;
      return b;
   endfunction

endpackage

// File: rtl/exe_operand_stage_fwd_mux.sv
// fwd_mux: picks the freshest value of one source register.
// Ports: i_addr/i_data stored operand, i_mem_*/i_wb_* producers, o_data.
module fwd_mux (
   input  logic [4:0]  i_addr,
   input  logic [31:0] i_data,
   input  logic        i_mem_en,
   input  logic [4:0]  i_mem_addr,
   input  logic [31:0] i_mem_data,
   input  logic        i_wb_en,
   input  logic [4:0]  i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic [31:0] o_data
);

   // $0 is hard-wired; MEM is younger than WB so it wins.
   always_comb begin
      o_data = i_data;
      if (i_addr == 5'd0)
         o_data = '0;
      else if (i_mem_en && (i_mem_addr == i_addr))
         o_data = i_mem_data;
      else if (i_wb_en && (i_wb_addr == i_addr))
         o_data = i_wb_data;
   end

endmodule

// File: rtl/exe_operand_stage.sv
// ID/EX register and ALU operand delivery with MEM/WB forwarding and
// load-use bubble insertion. Ports: clk/rst, exe_en/exe_flush control,
// id_* decoded inputs, mem_fwd_*/wb_fwd_* producers, load_use_stall,
// exe_* registered fields, alu_a/alu_b/alu_oper, exe_store_data.
module exe_operand_stage
   import exe_operand_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        exe_en,
   input  logic        exe_flush,
   input  logic        id_valid,
   input  logic [31:0] id_inst,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [31:0] id_imm_ext,
   input  logic [4:0]  id_rs_addr,
   input  logic [4:0]  id_rt_addr,
   input  logic [4:0]  id_wb_addr,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        id_wb_en,
   input  logic        id_mem_ren,
   input  logic        id_mem_wen,
   input  logic [3:0]  id_alu_oper,
   input  logic [1:0]  id_a_sel,
   input  logic [1:0]  id_b_sel,
   input  logic        mem_fwd_en,
   input  logic [4:0]  mem_fwd_addr,
   input  logic [31:0] mem_fwd_data,
   input  logic        wb_fwd_en,
   input  logic [4:0]  wb_fwd_addr,
   input  logic [31:0] wb_fwd_data,
   output logic        load_use_stall,
   output logic        exe_valid,
   output logic [31:0] exe_inst,
   output logic [31:0] exe_pc,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_oper,
   output logic [31:0] exe_store_data,
   output logic [4:0]  exe_wb_addr,
   output logic        exe_wb_en,
   output logic        exe_mem_ren,
   output logic        exe_mem_wen
);

   id_ex_t      r_ex;
   id_ex_t      w_id;
   logic [31:0] w_fwd_rs;
   logic [31:0] w_fwd_rt;
   logic        w_hit_rs;
   logic        w_hit_rt;

   fwd_mux u_fwd_rs (
      .i_addr     (r_ex.rs_addr),
      .i_data     (r_ex.rs_data),
      .i_mem_en   (mem_fwd_en),
      .i_mem_addr (mem_fwd_addr),
      .i_mem_data (mem_fwd_data),
      .i_wb_en    (wb_fwd_en),
      .i_wb_addr  (wb_fwd_addr),
      .i_wb_data  (wb_fwd_data),
      .o_data     (w_fwd_rs)
   );

   fwd_mux u_fwd_rt (
      .i_addr     (r_ex.rt_addr),
      .i_data     (r_ex.rt_data),
      .i_mem_en   (mem_fwd_en),
      .i_mem_addr (mem_fwd_addr),
      .i_mem_data (mem_fwd_data),
      .i_wb_en    (wb_fwd_en),
      .i_wb_addr  (wb_fwd_addr),
      .i_wb_data  (wb_fwd_data),
      .o_data     (w_fwd_rt)
   );

   always_comb begin
      w_id          = '0;
      w_id.valid    = id_valid;
      w_id.inst     = id_inst;
      w_id.pc       = id_pc;
      w_id.rs_data  = id_rs_data;
      w_id.rt_data  = id_rt_data;
      w_id.imm_ext  = id_imm_ext;
      w_id.rs_addr  = id_rs_addr;
      w_id.rt_addr  = id_rt_addr;
      w_id.wb_addr  = id_wb_addr;
      w_id.wb_en    = id_wb_en;
      w_id.mem_ren  = id_mem_ren;
      w_id.mem_wen  = id_mem_wen;
      w_id.alu_oper = id_alu_oper;
      w_id.a_sel    = id_a_sel;
      w_id.b_sel    = id_b_sel;
   end

   assign w_hit_rs = id_use_rs && (id_rs_addr == r_ex.wb_addr);
   assign w_hit_rt = id_use_rt && (id_rt_addr == r_ex.wb_addr);

   // While EX holds, the consumer stays in ID and nothing is lost.
   assign load_use_stall = exe_en && id_valid && r_ex.valid &&
                           r_ex.mem_ren && r_ex.wb_en &&
                           (r_ex.wb_addr != 5'd0) &&
                           (w_hit_rs || w_hit_rt);

   // On hold the forwarded operands are written back so a producer
   // that retires during a long stall is still seen afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex <= bubble();
      end else if (exe_flush) begin
         r_ex <= bubble();
      end else if (!exe_en) begin
         r_ex.rs_data <= w_fwd_rs;
         r_ex.rt_data <= w_fwd_rt;
      end else if (load_use_stall) begin
         r_ex <= bubble();
      end else begin
         r_ex <= w_id;
      end
   end

   always_comb begin
      alu_a = w_fwd_rs;
      unique case (r_ex.a_sel)
         EXE_A_RS:  alu_a = w_fwd_rs;
         EXE_A_SA:  alu_a = {27'b0, r_ex.inst[10:6]};
         EXE_A_PC:  alu_a = r_ex.pc;
         EXE_A_RSV: alu_a = {27'b0, w_fwd_rs[4:0]};
         default:   alu_a = w_fwd_rs;
      endcase
   end

   always_comb begin
      alu_b = w_fwd_rt;
      unique case (r_ex.b_sel)
         EXE_B_RT:   alu_b = w_fwd_rt;
         EXE_B_IMM:  alu_b = r_ex.imm_ext;
         EXE_B_FOUR: alu_b = 32'd4;
         EXE_B_ZERO: alu_b = '0;
         default:    alu_b = w_fwd_rt;
      endcase
   end

   assign exe_store_data = w_fwd_rt;
   assign exe_valid      = r_ex.valid;
   assign exe_inst       = r_ex.inst;
   assign exe_pc         = r_ex.pc;
   assign alu_oper       = r_ex.alu_oper;
   assign exe_wb_addr    = r_ex.wb_addr;
   assign exe_wb_en      = r_ex.wb_en;
   assign exe_mem_ren    = r_ex.mem_ren;
   assign exe_mem_wen    = r_ex.mem_wen;

endmodule

// File: tb/tb_exe_operand_stage.sv
// Directed bench for exe_operand_stage: expectations are queued as
// stimulus is driven and drained against the DUT outputs.
module tb_exe_operand_stage;
   import exe_operand_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        exe_en, exe_flush;
   logic        id_valid;
   logic [31:0] id_inst, id_pc, id_rs_data, id_rt_data, id_imm_ext;
   logic [4:0]  id_rs_addr, id_rt_addr, id_wb_addr;
   logic        id_use_rs, id_use_rt, id_wb_en, id_mem_ren, id_mem_wen;
   logic [3:0]  id_alu_oper;
   logic [1:0]  id_a_sel, id_b_sel;
   logic        mem_fwd_en, wb_fwd_en;
   logic [4:0]  mem_fwd_addr, wb_fwd_addr;
   logic [31:0] mem_fwd_data, wb_fwd_data;
   logic        load_use_stall, exe_valid;
   logic [31:0] exe_inst, exe_pc, alu_a, alu_b, exe_store_data;
   logic [3:0]  alu_oper;
   logic [4:0]  exe_wb_addr;
   logic        exe_wb_en, exe_mem_ren, exe_mem_wen;

   exe_operand_stage dut (
      .clk(clk), .rst(rst), .exe_en(exe_en), .exe_flush(exe_flush),
      .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm_ext(id_imm_ext), .id_rs_addr(id_rs_addr),
      .id_rt_addr(id_rt_addr), .id_wb_addr(id_wb_addr),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_wb_en(id_wb_en), .id_mem_ren(id_mem_ren),
      .id_mem_wen(id_mem_wen), .id_alu_oper(id_alu_oper),
      .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
      .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr),
      .mem_fwd_data(mem_fwd_data), .wb_fwd_en(wb_fwd_en),
      .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
      .load_use_stall(load_use_stall), .exe_valid(exe_valid),
      .exe_inst(exe_inst), .exe_pc(exe_pc), .alu_a(alu_a),
      .alu_b(alu_b), .alu_oper(alu_oper),
      .exe_store_data(exe_store_data), .exe_wb_addr(exe_wb_addr),
      .exe_wb_en(exe_wb_en), .exe_mem_ren(exe_mem_ren),
      .exe_mem_wen(exe_mem_wen)
   );

   always #5 clk = ~clk;

   typedef enum int {
      S_VALID, S_INST, S_PC, S_A, S_B, S_OPER, S_SD,
      S_WBA, S_WBEN, S_REN, S_WEN, S_STALL
   } sig_e;

   typedef struct {
      string       tag;
      sig_e        sig;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] obs(sig_e s);
      case (s)
         S_VALID: return {31'b0, exe_valid};
         S_INST:  return exe_inst;
         S_PC:    return exe_pc;
         S_A:     return alu_a;
         S_B:     return alu_b;
         S_OPER:  return {28'b0, alu_oper};
         S_SD:    return exe_store_data;
         S_WBA:   return {27'b0, exe_wb_addr};
         S_WBEN:  return {31'b0, exe_wb_en};
         S_REN:   return {31'b0, exe_mem_ren};
         S_WEN:   return {31'b0, exe_mem_wen};
         default: return {31'b0, load_use_stall};
      endcase
   endfunction

   task automatic expect_v(input string tag, input sig_e s,
                           input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sig = s;
      e.val = v;
      q.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] o;
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         o = obs(e.sig);
         checks++;
         assert (o === e.val) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(
      input logic [31:0] inst, pc, rs_d, rt_d, imm,
      input logic [4:0]  rs_a, rt_a, wb_a,
      input logic        urs, urt, wbe, ren, wen,
      input logic [3:0]  oper,
      input logic [1:0]  asel, bsel
   );
      id_valid    = 1'b1;
      id_inst     = inst;
      id_pc       = pc;
      id_rs_data  = rs_d;
      id_rt_data  = rt_d;
      id_imm_ext  = imm;
      id_rs_addr  = rs_a;
      id_rt_addr  = rt_a;
      id_wb_addr  = wb_a;
      id_use_rs   = urs;
      id_use_rt   = urt;
      id_wb_en    = wbe;
      id_mem_ren  = ren;
      id_mem_wen  = wen;
      id_alu_oper = oper;
      id_a_sel    = asel;
      id_b_sel    = bsel;
   endtask

   task automatic idle_id();
      drive_id('0, '0, '0, '0, '0, '0, '0, '0,
               0, 0, 0, 0, 0, EXE_ALU_ADD, EXE_A_RS, EXE_B_RT);
      id_valid = 1'b0;
   endtask

   task automatic no_fwd();
      mem_fwd_en   = 1'b0;
      mem_fwd_addr = '0;
      mem_fwd_data = '0;
      wb_fwd_en    = 1'b0;
      wb_fwd_addr  = '0;
      wb_fwd_data  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      exe_en    = 1'b1;
      exe_flush = 1'b0;
      idle_id();
      no_fwd();
      tick();
      tick();
      expect_v("rst_valid", S_VALID, 0);
      expect_v("rst_oper", S_OPER, {28'b0, EXE_ALU_ADD});
      expect_v("rst_a", S_A, 0);
      expect_v("rst_b", S_B, 0);
      expect_v("rst_inst", S_INST, 0);
      expect_v("rst_sd", S_SD, 0);
      expect_v("rst_wben", S_WBEN, 0);
      expect_v("rst_stall", S_STALL, 0);
      drain();
      rst = 1'b0;

      // add $3,$1,$2 with MEM forward of $1
      drive_id(32'h00221820, 32'h100, 32'd5, 32'd7, 0, 5'd1, 5'd2, 5'd3,
               1, 1, 1, 0, 0, EXE_ALU_ADD, EXE_A_RS, EXE_B_RT);
      tick();
      idle_id();
      mem_fwd_en = 1; mem_fwd_addr = 5'd1; mem_fwd_data = 32'h100;
      expect_v("add_memfwd_a", S_A, 32'h100);
      expect_v("add_b", S_B, 32'd7);
      expect_v("add_valid", S_VALID, 1);
      expect_v("add_pc", S_PC, 32'h100);
      expect_v("add_wba", S_WBA, 3);
      expect_v("add_sd", S_SD, 7);
      drain();
      wb_fwd_en = 1; wb_fwd_addr = 5'd1; wb_fwd_data = 32'h20;
      mem_fwd_data = 32'h30;
      expect_v("mem_over_wb", S_A, 32'h30);
      drain();
      mem_fwd_en = 0;
      expect_v("wb_fwd_a", S_A, 32'h20);
      drain();
      wb_fwd_en = 0;
      expect_v("stored_a", S_A, 32'd5);
      drain();

      // rs = $0 ignores a forward aimed at $0
      drive_id(32'h00021820, 32'h104, 32'h55, 32'h66, 0, 5'd0, 5'd2,
               5'd3, 1, 1, 1, 0, 0, EXE_ALU_ADD, EXE_A_RS, EXE_B_RT);
      tick();
      idle_id();
      mem_fwd_en = 1; mem_fwd_addr = 5'd0; mem_fwd_data = 32'h99;
      wb_fwd_en = 1; wb_fwd_addr = 5'd0; wb_fwd_data = 32'h98;
      expect_v("r0_a", S_A, 0);
      expect_v("r0_b", S_B, 32'h66);
      drain();
      no_fwd();

      // lw $4 then add $5,$4,$4
      drive_id(32'h8FA40010, 32'h108, 32'h1000, 0, 32'h10, 5'd29, 5'd4,
               5'd4, 1, 0, 1, 1, 0, EXE_ALU_ADD, EXE_A_RS, EXE_B_IMM);
      tick();
      expect_v("lw_a", S_A, 32'h1000);
      expect_v("lw_b", S_B, 32'h10);
      expect_v("lw_ren", S_REN, 1);
      drive_id(32'h00842820, 32'h10C, 32'hDEAD, 32'hDEAD, 0, 5'd4, 5'd4,
               5'd5, 1, 1, 1, 0, 0, EXE_ALU_ADD, EXE_A_RS, EXE_B_RT);
      expect_v("lu_stall", S_STALL, 1);
      drain();
      tick();
      expect_v("bub_valid", S_VALID, 0);
      expect_v("bub_wben", S_WBEN, 0);
      expect_v("bub_ren", S_REN, 0);
      expect_v("bub_oper", S_OPER, {28'b0, EXE_ALU_ADD});
      expect_v("bub_inst", S_INST, 0);
      expect_v("bub_stall", S_STALL, 0);
      drain();
      tick();
      mem_fwd_en = 1; mem_fwd_addr = 5'd4; mem_fwd_data = 32'hABCD;
      expect_v("lu_valid", S_VALID, 1);
      expect_v("lu_pc", S_PC, 32'h10C);
      expect_v("lu_a", S_A, 32'hABCD);
      expect_v("lu_b", S_B, 32'hABCD);
      expect_v("lu_nostall", S_STALL, 0);
      drain();
      no_fwd();

      // stall masked on hold; flush with stall gives one bubble
      drive_id(32'h8FA40010, 32'h110, 32'h1000, 0, 32'h10, 5'd29, 5'd4,
               5'd4, 1, 0, 1, 1, 0, EXE_ALU_ADD, EXE_A_RS, EXE_B_IMM);
      tick();
      drive_id(32'h00842820, 32'h114, 0, 0, 0, 5'd4, 5'd4, 5'd5,
               1, 1, 1, 0, 0, EXE_ALU_ADD, EXE_A_RS, EXE_B_RT);
      exe_en = 0;
      expect_v("stall_masked", S_STALL, 0);
      drain();
      exe_en = 1;
      expect_v("stall_unmasked", S_STALL, 1);
      drain();
      exe_flush = 1;
      tick();
      exe_flush = 0;
      expect_v("flush_valid", S_VALID, 0);
      expect_v("flush_stall", S_STALL, 0);
      drain();
      tick();
      expect_v("after_flush_valid", S_VALID, 1);
      expect_v("after_flush_pc", S_PC, 32'h114);
      drain();

      // shifts, jal, immediate, store
      drive_id(32'h00031140, 32'h118, 0, 32'h11, 0, 5'd0, 5'd3, 5'd2,
               0, 1, 1, 0, 0, EXE_ALU_SLL, EXE_A_SA, EXE_B_RT);
      tick();
      expect_v("sll_a", S_A, 32'd5);
      expect_v("sll_b", S_B, 32'h11);
      expect_v("sll_oper", S_OPER, {28'b0, EXE_ALU_SLL});
      drive_id(32'h00C31004, 32'h11C, 32'h25, 32'h11, 0, 5'd6, 5'd3,
               5'd2, 1, 1, 1, 0, 0, EXE_ALU_SLL, EXE_A_RSV, EXE_B_RT);
      drain();
      tick();
      expect_v("sllv_a", S_A, 32'd5);
      drive_id(32'h0C000010, 32'h40, 0, 0, 0, 5'd0, 5'd0, 5'd31,
               0, 0, 1, 0, 0, EXE_ALU_ADD, EXE_A_PC, EXE_B_FOUR);
      drain();
      tick();
      expect_v("jal_a", S_A, 32'h40);
      expect_v("jal_b", S_B, 32'd4);
      expect_v("jal_wba", S_WBA, 31);
      drive_id(32'h21098000, 32'h44, 32'd3, 0, 32'hFFFF8000, 5'd8,
               5'd9, 5'd9, 1, 0, 1, 0, 0, EXE_ALU_ADD, EXE_A_RS,
               EXE_B_IMM);
      drain();
      tick();
      expect_v("imm_a", S_A, 32'd3);
      expect_v("imm_b", S_B, 32'hFFFF8000);
      drive_id(32'hAD2A0000, 32'h48, 32'h9, 32'h1234, 0, 5'd9, 5'd10,
               5'd0, 1, 1, 0, 0, 1, EXE_ALU_ADD, EXE_A_RS, EXE_B_ZERO);
      drain();
      tick();
      expect_v("sw_b_zero", S_B, 0);
      expect_v("sw_sd", S_SD, 32'h1234);
      expect_v("sw_wen", S_WEN, 1);
      expect_v("sw_wben", S_WBEN, 0);
      drain();
      mem_fwd_en = 1; mem_fwd_addr = 5'd10; mem_fwd_data = 32'h5678;
      expect_v("sw_sd_fwd", S_SD, 32'h5678);
      expect_v("sw_b_zero_fwd", S_B, 0);
      drain();
      no_fwd();

      // hold for 3 cycles while the WB producer of rs retires
      drive_id(32'h00E01820, 32'h200, 32'd1, 0, 0, 5'd7, 5'd0, 5'd3,
               1, 0, 1, 0, 0, EXE_ALU_ADD, EXE_A_RS, EXE_B_RT);
      tick();
      idle_id();
      wb_fwd_en = 1; wb_fwd_addr = 5'd7; wb_fwd_data = 32'h77;
      exe_en = 0;
      expect_v("hold_fwd_a", S_A, 32'h77);
      drain();
      tick();
      wb_fwd_en = 0;
      expect_v("hold_retired_a", S_A, 32'h77);
      drain();
      tick();
      tick();
      expect_v("hold_end_a", S_A, 32'h77);
      expect_v("hold_valid", S_VALID, 1);
      expect_v("hold_pc", S_PC, 32'h200);
      drain();

      // flush wins over hold
      exe_flush = 1;
      tick();
      exe_flush = 0;
      exe_en = 1;
      expect_v("flush_hold_valid", S_VALID, 0);
      expect_v("flush_hold_a", S_A, 0);
      drain();

      // asynchronous reset mid-stream
      drive_id(32'h00201820, 32'h300, 32'h42, 0, 0, 5'd1, 5'd0, 5'd3,
               1, 0, 1, 0, 0, EXE_ALU_SUB, EXE_A_RS, EXE_B_RT);
      tick();
      expect_v("pre_rst_valid", S_VALID, 1);
      expect_v("pre_rst_a", S_A, 32'h42);
      drain();
      #1;
      rst = 1;
      expect_v("arst_valid", S_VALID, 0);
      expect_v("arst_oper", S_OPER, {28'b0, EXE_ALU_ADD});
      expect_v("arst_pc", S_PC, 0);
      expect_v("arst_a", S_A, 0);
      expect_v("arst_wben", S_WBEN, 0);
      drain();
      rst = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
